// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path:
// FSM state encodings and the bit-counter width helper.
package serial_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // A one-bit word still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// N-bit parallel-load shift register; q is the bit
// at the output end selected by MSB_FIRST.
module shift_reg_piso #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [N-1:0] d,
   output logic         q
);

   logic [N-1:0] shreg;
   logic [N-1:0] nxt;

   generate
      if (N == 1) begin : g_one
         assign nxt = '0;
      end else if (MSB_FIRST) begin : g_msb
         assign nxt = {shreg[N-2:0], 1'b0};
      end else begin : g_lsb
         assign nxt = {1'b0, shreg[N-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= d;
      end else if (shift) begin
         shreg <= nxt;
      end
   end

   assign q = MSB_FIRST ? shreg[N-1] : shreg[0];

endmodule

// File: rtl/parallel_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word
// on valid/ready, shifts it out per tick, pulses done.
module parallel_serializer
   import serial_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   input  logic [N-1:0] D,
   output logic         load_ready,
   input  logic         tick,
   output logic         sdata,
   output logic         sframe,
   output logic         done
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last;
   logic          advance;
   logic          q;

   // load_ready and sframe are registered copies of IDLE and SHIFT.
   assign accept  = load_ready & load_valid;
   assign last    = (cnt == LAST);
   assign advance = sframe & tick & ~last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         load_ready <= 1'b1;
         sframe     <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load_valid) begin
                  state      <= SHIFT;
                  cnt        <= '0;
                  load_ready <= 1'b0;
                  sframe     <= 1'b1;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (last) begin
                     state  <= DONE;
                     sframe <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               load_ready <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b1;
               sframe     <= 1'b0;
            end
         endcase
      end
   end

   shift_reg_piso #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (advance),
      .d     (D),
      .q     (q)
   );

   assign sdata = sframe & q;

endmodule
